// File: rtl/rx_byte_assembler.sv
// rx_byte_assembler: removes USB stuffed bits from the decoded bit stream and packs the remaining
// data bits LSB-first into NBITS-wide bytes, with a sticky flag for bit-stuffing violations.
`default_nettype none

module rx_byte_assembler #(
  parameter int NBITS     = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_orig,
  input  logic             shift_enable,
  input  logic             eop,
  input  logic             clear,
  output logic [NBITS-1:0] rcv_data,
  output logic             byte_received,
  output logic             stuff_error
);

  localparam int BW = $clog2(NBITS + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

  logic [NBITS-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [OW-1:0]    ones_cnt;
  logic [NBITS-1:0] shifted;

  assign shifted = {d_orig, shreg[NBITS-1:1]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      ones_cnt      <= '0;
      rcv_data      <= '0;
      byte_received <= 1'b0;
      stuff_error   <= 1'b0;
    end else begin
      byte_received <= 1'b0;
      if (clear) begin
        shreg       <= '0;
        bit_cnt     <= '0;
        ones_cnt    <= '0;
        stuff_error <= 1'b0;
      end else if (eop) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
      end else if (shift_enable) begin
        if (ones_cnt == ONES_MAX) begin
          // Stuffed-bit slot: a 1 here means the transmitter broke the stuffing rule.
          ones_cnt <= '0;
          if (d_orig) begin
            stuff_error <= 1'b1;
          end
        end else begin
          shreg    <= shifted;
          ones_cnt <= d_orig ? ones_cnt + OW'(1) : '0;
          if (bit_cnt == LAST_BIT) begin
            rcv_data      <= shifted;
            byte_received <= 1'b1;
            bit_cnt       <= '0;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_byte_assembler.sv
// Directed table-driven bench for rx_byte_assembler.
`default_nettype none

module tb_rx_byte_assembler;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_orig = 1'b0;
  logic       shift_enable = 1'b0;
  logic       eop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] rcv_data;
  logic       byte_received;
  logic       stuff_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       clr;
    logic       eop;
    logic       se;
    logic       d;
    logic       br;
    logic [7:0] data;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  rx_byte_assembler #(.NBITS(8), .STUFF_LEN(6)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .d_orig        (d_orig),
    .shift_enable  (shift_enable),
    .eop           (eop),
    .clear         (clear),
    .rcv_data      (rcv_data),
    .byte_received (byte_received),
    .stuff_error   (stuff_error)
  );

  always #5 clk = ~clk;

  task automatic add(input logic c, input logic e, input logic s, input logic d,
                     input logic br, input logic [7:0] data, input logic err);
    vec_t v;
    v.clr = c; v.eop = e; v.se = s; v.d = d; v.br = br; v.data = data; v.err = err;
    vecs.push_back(v);
  endtask

  // Strobe a bit with no pulse expected.
  task automatic bit_np(input logic d, input logic [7:0] data, input logic err);
    add(1'b0, 1'b0, 1'b1, d, 1'b0, data, err);
  endtask

  task automatic check(input string tag, input logic br, input logic [7:0] data, input logic err);
    checks++;
    if (byte_received !== br || rcv_data !== data || stuff_error !== err) begin
      errors++;
      $display("FAIL %s: got br=%b data=%h err=%b, expected br=%b data=%h err=%b",
               tag, byte_received, rcv_data, stuff_error, br, data, err);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    clear = v.clr; eop = v.eop; shift_enable = v.se; d_orig = v.d;
    @(posedge clk);
    #1;
    check(tag, v.br, v.data, v.err);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("%s[%0d]", name, i));
    end
    vecs.delete();
    @(negedge clk);
    clear = 1'b0; eop = 1'b0; shift_enable = 1'b0; d_orig = 1'b0;
  endtask

  initial begin
    // Reset state before any clock edge and while held.
    #2;
    check("reset_async", 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    // Sync byte 0x80.
    for (int i = 0; i < 7; i++) bit_np(1'b0, 8'h00, 1'b0);
    add(0, 0, 1, 1, 1, 8'h80, 0);
    add(0, 0, 0, 0, 0, 8'h80, 0);
    add(1, 0, 0, 0, 0, 8'h80, 0);

    // Stuff removal: 1x6, stuffed 0, 1, 1 -> 0xFF on the 9th strobe; then 0x00.
    for (int i = 0; i < 6; i++) bit_np(1'b1, 8'h80, 1'b0);
    bit_np(1'b0, 8'h80, 1'b0);
    bit_np(1'b1, 8'h80, 1'b0);
    add(0, 0, 1, 1, 1, 8'hFF, 0);
    for (int i = 0; i < 7; i++) bit_np(1'b0, 8'hFF, 1'b0);
    add(0, 0, 1, 0, 1, 8'h00, 0);

    // Stuffed bit straddling a byte boundary: 0xFC, stuffed 0, then 0x0F.
    bit_np(1'b0, 8'h00, 1'b0);
    bit_np(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) bit_np(1'b1, 8'h00, 1'b0);
    add(0, 0, 1, 1, 1, 8'hFC, 0);
    bit_np(1'b0, 8'hFC, 1'b0);
    for (int i = 0; i < 4; i++) bit_np(1'b1, 8'hFC, 1'b0);
    for (int i = 0; i < 3; i++) bit_np(1'b0, 8'hFC, 1'b0);
    add(0, 0, 1, 0, 1, 8'h0F, 0);

    // Stuff violation: 1x7, flag sticks through idle, clear drops it.
    for (int i = 0; i < 6; i++) bit_np(1'b1, 8'h0F, 1'b0);
    bit_np(1'b1, 8'h0F, 1'b1);
    add(0, 0, 0, 0, 0, 8'h0F, 1);
    add(1, 0, 0, 0, 0, 8'h0F, 0);

    // EOP mid-byte with a simultaneous strobe, then 0xA5.
    bit_np(1'b1, 8'h0F, 1'b0);
    bit_np(1'b1, 8'h0F, 1'b0);
    bit_np(1'b0, 8'h0F, 1'b0);
    bit_np(1'b1, 8'h0F, 1'b0);
    bit_np(1'b0, 8'h0F, 1'b0);
    add(0, 1, 1, 1, 0, 8'h0F, 0);
    bit_np(1'b1, 8'h0F, 1'b0);
    bit_np(1'b0, 8'h0F, 1'b0);
    bit_np(1'b1, 8'h0F, 1'b0);
    bit_np(1'b0, 8'h0F, 1'b0);
    bit_np(1'b0, 8'h0F, 1'b0);
    bit_np(1'b1, 8'h0F, 1'b0);
    bit_np(1'b0, 8'h0F, 1'b0);
    add(0, 0, 1, 1, 1, 8'hA5, 0);

    // EOP keeps stuff_error; clear beats eop and a strobe in the same cycle.
    bit_np(1'b0, 8'hA5, 1'b0);
    for (int i = 0; i < 6; i++) bit_np(1'b1, 8'hA5, 1'b0);
    bit_np(1'b1, 8'hA5, 1'b1);
    add(0, 1, 0, 0, 0, 8'hA5, 1);
    add(1, 1, 1, 1, 0, 8'hA5, 0);
    run_table("main");

    // Async reset mid-byte while stuff_error is set.
    for (int i = 0; i < 6; i++) bit_np(1'b1, 8'hA5, 1'b0);
    bit_np(1'b1, 8'hA5, 1'b1);
    run_table("pre_rst");
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_mid_cycle", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    // 0x3C after reset: partial byte must have been discarded.
    bit_np(1'b0, 8'h00, 1'b0);
    bit_np(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) bit_np(1'b1, 8'h00, 1'b0);
    bit_np(1'b0, 8'h00, 1'b0);
    add(0, 0, 1, 0, 1, 8'h3C, 0);
    add(0, 0, 0, 0, 0, 8'h3C, 0);
    run_table("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
